// File: rtl/tjmono_hit_splitter.sv
// tjmono_hit_splitter
// Splits one wide hit record into 32-bit words and queues them in a show-ahead
// output FIFO. Each word is {IDENTIFIER, idx, slice}, where slice idx is the
// idx-th SLICE_WIDTH-bit chunk of the record. The least significant chunk goes
// out first.
//
// Ports
//   BUS_CLK     sole clock, rising edge
//   BUS_RST     asynchronous active-high reset
//   ENABLE      permits acceptance of new records
//   SHORT_MODE  emit SHORT_WORDS instead of NUM_WORDS words for the next record
//   IN_DATA     hit record, IN_VALID qualifies it
//   IN_READY    record accepted on this cycle's edge when IN_VALID is also high
//   FIFO_READ   pop one word (ignored while FIFO_EMPTY)
//   FIFO_EMPTY  no word available
//   FIFO_DATA   head word of the FIFO (show-ahead, don't-care while empty)
//   WORD_CNT    wrapping count of words written into the FIFO
//   BUSY        a record is being split (FSM is in SEND)
//
// Handshake: a record transfers on a rising edge where IN_VALID and IN_READY
// are both high. IN_READY depends only on the FSM state, ENABLE and BUS_RST,
// never on IN_VALID. The source must hold IN_DATA stable while IN_VALID is high
// and IN_READY is low.
module tjmono_hit_splitter #(
  parameter int         IN_WIDTH    = 112,
  parameter int         IDX_WIDTH   = 2,
  parameter logic [1:0] IDENTIFIER  = 2'b00,
  parameter int         SHORT_WORDS = 1,
  parameter int         DEPTH       = 1024
) (
  input  logic                BUS_CLK,
  input  logic                BUS_RST,
  input  logic                ENABLE,
  input  logic                SHORT_MODE,
  input  logic [IN_WIDTH-1:0] IN_DATA,
  input  logic                IN_VALID,
  output logic                IN_READY,
  input  logic                FIFO_READ,
  output logic                FIFO_EMPTY,
  output logic [31:0]         FIFO_DATA,
  output logic [31:0]         WORD_CNT,
  output logic                BUSY
);

  localparam int SLICE_WIDTH = 30 - IDX_WIDTH;
  localparam int NUM_WORDS   = (IN_WIDTH + SLICE_WIDTH - 1) / SLICE_WIDTH;
  localparam int BUF_WIDTH   = NUM_WORDS * SLICE_WIDTH;
  localparam int AW          = $clog2(DEPTH);
  localparam int CW          = IDX_WIDTH + 1;  // holds counts up to 2^IDX_WIDTH

  localparam logic [CW-1:0] NUM_CNT   = CW'(NUM_WORDS);
  localparam logic [CW-1:0] SHORT_CNT = CW'(SHORT_WORDS);
  localparam logic [AW:0]   FULL_OCC  = (AW + 1)'(DEPTH);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t                 state;
  logic [BUF_WIDTH-1:0]   buffer;
  logic [BUF_WIDTH-1:0]   in_ext;
  logic [IDX_WIDTH-1:0]   idx;
  logic [CW-1:0]          count;
  logic [SLICE_WIDTH-1:0] slice;
  logic [31:0]            word;
  logic                   last_word;

  logic [31:0]            mem [DEPTH];
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic [AW:0]            occupancy;
  logic                   full;
  logic                   do_write;
  logic                   do_read;

  // Zero-extend the record so the top slice is padded with zeros.
  always_comb begin
    in_ext = '0;
    in_ext[IN_WIDTH-1:0] = IN_DATA;
  end

  assign slice     = buffer[int'(idx) * SLICE_WIDTH +: SLICE_WIDTH];
  assign word      = {IDENTIFIER, idx, slice};
  assign last_word = ({1'b0, idx} == count - 1'b1);

  // Full is judged on the occupancy before any same-cycle pop, so a full FIFO
  // never takes a write even while it is being read.
  assign full       = (occupancy == FULL_OCC);
  assign FIFO_EMPTY = (occupancy == '0);
  assign do_write   = (state == SEND) && !full;
  assign do_read    = FIFO_READ && !FIFO_EMPTY;

  assign IN_READY  = (state == IDLE) && ENABLE && !BUS_RST;
  assign BUSY      = (state == SEND);
  assign FIFO_DATA = mem[rd_ptr];

  // Splitter FSM. Word count and record are latched at acceptance, so later
  // changes of SHORT_MODE or ENABLE do not touch the record in progress.
  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) begin
      state  <= IDLE;
      idx    <= '0;
      count  <= '0;
      buffer <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (IN_VALID && IN_READY) begin
            buffer <= in_ext;
            count  <= SHORT_MODE ? SHORT_CNT : NUM_CNT;
            idx    <= '0;
            state  <= SEND;
          end
        end
        SEND: begin
          if (do_write) begin
            if (last_word) begin
              idx   <= '0;
              state <= IDLE;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Storage array has no reset; only pointers and occupancy define contents.
  always_ff @(posedge BUS_CLK) begin
    if (do_write) mem[wr_ptr] <= word;
  end

  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
      WORD_CNT  <= '0;
    end else begin
      if (do_write) begin
        wr_ptr   <= wr_ptr + 1'b1;
        WORD_CNT <= WORD_CNT + 32'd1;
      end
      if (do_read) rd_ptr <= rd_ptr + 1'b1;
      case ({do_write, do_read})
        2'b10:   occupancy <= occupancy + 1'b1;
        2'b01:   occupancy <= occupancy - 1'b1;
        default: occupancy <= occupancy;
      endcase
    end
  end

endmodule

// File: doc/tjmono_hit_splitter.md
TJMONO_HIT_SPLITTER -- requirements
Module: tjmono_hit_splitter

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 112, meaning width of one hit record.
REQ-002 SHALL have parameter IDX_WIDTH, default 2, meaning width of the per-word slice index field.
REQ-003 SHALL have parameter IDENTIFIER, default 2'b00, meaning channel tag in FIFO_DATA[31:30].
REQ-004 SHALL have parameter SHORT_WORDS, default 1, meaning words emitted per record in short mode.
REQ-005 SHALL have parameter DEPTH, default 1024 (power of two), meaning output FIFO depth in words.
REQ-006 SHALL derive SLICE_WIDTH = 30-IDX_WIDTH and NUM_WORDS = ceil(IN_WIDTH/SLICE_WIDTH); NUM_WORDS <= 2^IDX_WIDTH and 1 <= SHORT_WORDS <= NUM_WORDS are legal-configuration constraints.
REQ-007 BUS_CLK  in  1  sole clock; all state on its rising edge.
REQ-008 BUS_RST  in  1  reset, asynchronous, active-high.
REQ-009 ENABLE  in  1  permits acceptance of new records.
REQ-010 SHORT_MODE  in  1  selects SHORT_WORDS instead of NUM_WORDS per record.
REQ-011 IN_DATA  in  IN_WIDTH  hit record.
REQ-012 IN_VALID  in  1  IN_DATA valid.
REQ-013 IN_READY  out  1  block accepts record this cycle.
REQ-014 FIFO_READ  in  1  pop one output word.
REQ-015 FIFO_EMPTY  out  1  no word available.
REQ-016 FIFO_DATA  out  32  {IDENTIFIER, idx[IDX_WIDTH-1:0], slice[SLICE_WIDTH-1:0]}, show-ahead.
REQ-017 WORD_CNT  out  32  total words written to the output FIFO.
REQ-018 BUSY  out  1  high while a record is being split.

Function
REQ-019 SHALL implement a two-state FSM: IDLE, SEND.
REQ-020 SHALL drive IN_READY = (state==IDLE) & ENABLE combinationally.
REQ-021 On an edge with IN_VALID & IN_READY: latch IN_DATA zero-extended to NUM_WORDS*SLICE_WIDTH bits, latch word count (SHORT_MODE ? SHORT_WORDS : NUM_WORDS), idx<=0, state<=SEND.
REQ-022 SHORT_MODE and ENABLE changes after acceptance SHALL NOT affect the record in progress.
REQ-023 In SEND, each edge with FIFO not full SHALL write {IDENTIFIER, idx, slice idx} where slice idx = buffer[idx*SLICE_WIDTH +: SLICE_WIDTH], then idx<=idx+1.
REQ-024 Slice 0 (LSBs) SHALL be written first; words are strictly consecutive when not stalled.
REQ-025 Write of the last word (idx == count-1) SHALL return state to IDLE on the same edge; a new record is acceptable on the next cycle (throughput one record per count+1 cycles).
REQ-026 FIFO full SHALL stall SEND with idx held; no word is dropped or duplicated.
REQ-027 Full SHALL be evaluated before a same-cycle read: no write occurs when occupancy == DEPTH, even if FIFO_READ is high.
REQ-028 Simultaneous write and read when neither full nor empty SHALL leave occupancy unchanged.
REQ-029 FIFO_READ while FIFO_EMPTY SHALL be ignored.
REQ-030 Latency: record accepted at edge k, first word visible on FIFO_DATA with FIFO_EMPTY=0 after edge k+1.
REQ-031 WORD_CNT SHALL increment by 1 per word written and wrap from 2^32-1 to 0.
REQ-032 BUSY SHALL equal (state==SEND).

Reset
REQ-033 BUS_RST SHALL immediately, asynchronously: state=IDLE, idx=0, FIFO occupancy=0, FIFO_EMPTY=1, WORD_CNT=0, BUSY=0.
REQ-034 IN_READY SHALL be 0 while BUS_RST is high; a record partially split at reset SHALL be discarded entirely.
REQ-035 FIFO_DATA value while FIFO_EMPTY=1 is don't-care.

Verification
REQ-036 Defaults, IN_DATA={28'hDDDDDDD,28'hCCCCCCC,28'hBBBBBBB,28'hAAAAAAA}, one pulse -> FIFO words 0x0AAAAAAA, 0x1BBBBBBB, 0x2CCCCCCC, 0x3DDDDDDD in order, WORD_CNT=4, IN_READY high again 5 cycles after accept.
REQ-037 SHORT_MODE=1, same record -> only 0x0AAAAAAA written, WORD_CNT=1, IN_READY high 2 cycles after accept.
REQ-038 DEPTH=4, no reads, two records back-to-back -> 4 words stored, second record accepted, BUSY=1 stalled at idx 0; one FIFO_READ -> next edge writes 0x0 word of record 2.
REQ-039 BUS_RST asserted after 2 words of a record -> FIFO_EMPTY=1, WORD_CNT=0, BUSY=0 immediately; after release with ENABLE=1 IN_READY=1 and no residual words appear.
REQ-040 IN_WIDTH=100, IN_DATA all ones -> words 0x0FFFFFFF, 0x1FFFFFFF, 0x2FFFFFFF, 0x3000FFFF (top slice zero-padded).
REQ-041 ENABLE dropped one cycle after accept -> all 4 words still written; IN_READY stays 0 until ENABLE returns.
